// File: rtl/hkspi_pkg.sv
// Shared definitions for the housekeeping SPI responder: command field layout,
// command modes and the transaction state encoding.
package hkspi_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RW    = 2'b11
    } cmd_mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    localparam int CMD_MODE_MSB = 7;
    localparam int CMD_MODE_LSB = 6;
    localparam int CMD_N_MSB    = 5;
    localparam int CMD_N_LSB    = 3;

    function automatic logic mode_reads(input cmd_mode_t mode);
        return (mode == CMD_READ) || (mode == CMD_RW);
    endfunction

    function automatic logic mode_writes(input cmd_mode_t mode);
        return (mode == CMD_WRITE) || (mode == CMD_RW);
    endfunction

endpackage

// File: rtl/hkspi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with one extra delayed copy
// used to produce single-cycle rise and fall pulses in the core clock domain.
module hkspi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/hkspi_responder.sv
// SPI mode-0 responder giving an external host byte-wide access to the
// housekeeping register bank, with auto-incrementing address and optional byte limit.
module hkspi_responder
    import hkspi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_csb,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    logic sck_rise, sck_fall, csb_rise, csb_fall;

    hkspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (spi_sck),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    hkspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csb_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (spi_csb),
        .rise     (csb_rise),
        .fall     (csb_fall)
    );

    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    state_t                 state_q, state_d;
    cmd_mode_t              mode_q, mode_d;
    logic [2:0]             nbytes_q, nbytes_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [2:0]             bytecnt_q, bytecnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   inc_pend_q, inc_pend_d;
    logic                   load_pend_q, load_pend_d;
    logic                   sdo_q, sdo_d;
    logic                   sdo_oe_q, sdo_oe_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;
    logic                   busy_q, busy_d;
    logic [7:0]             rx_byte;
    logic                   last_bit;

    // Byte completion schedules the write strobe first, then the address
    // increment and read prefetch, so a read+write byte sees the old contents.
    always_comb begin
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
        rx_byte     = {rx_q[6:0], sdi_sync_q[SYNC_STAGES-1]};
        last_bit    = (bitcnt_q == 3'd7);

        state_d     = state_q;
        mode_d      = mode_q;
        nbytes_d    = nbytes_q;
        bitcnt_d    = bitcnt_q;
        bytecnt_d   = bytecnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        sdo_d       = sdo_q;
        sdo_oe_d    = sdo_oe_q;
        inc_pend_d  = 1'b0;
        load_pend_d = re_q;
        we_d        = 1'b0;
        re_d        = 1'b0;

        if (load_pend_q) begin
            tx_d = reg_rdata;
        end

        if (inc_pend_q) begin
            addr_d = addr_q + ADDR_W'(1);
            re_d   = mode_reads(mode_q) && (state_q == S_DATA);
        end

        case (state_q)
            S_IDLE: begin
                sdo_oe_d = 1'b0;
                if (csb_fall) begin
                    state_d   = S_CMD;
                    bitcnt_d  = 3'd0;
                    bytecnt_d = 3'd0;
                end
            end
            S_CMD: begin
                if (sck_rise) begin
                    rx_d     = rx_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (last_bit) begin
                        mode_d   = cmd_mode_t'(rx_byte[CMD_MODE_MSB:CMD_MODE_LSB]);
                        nbytes_d = rx_byte[CMD_N_MSB:CMD_N_LSB];
                        state_d  = (cmd_mode_t'(rx_byte[CMD_MODE_MSB:CMD_MODE_LSB]) == CMD_NOP)
                                   ? S_DONE : S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (sck_rise) begin
                    rx_d     = rx_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (last_bit) begin
                        addr_d  = ADDR_W'(rx_byte);
                        re_d    = mode_reads(mode_q);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (sck_fall && mode_reads(mode_q)) begin
                    sdo_d    = tx_q[3'd7 - bitcnt_q];
                    sdo_oe_d = 1'b1;
                end
                if (sck_rise) begin
                    rx_d     = rx_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (last_bit) begin
                        we_d       = mode_writes(mode_q);
                        wdata_d    = mode_writes(mode_q) ? rx_byte : wdata_q;
                        inc_pend_d = 1'b1;
                        bytecnt_d  = bytecnt_q + 3'd1;
                        if ((nbytes_q != 3'd0) && ((bytecnt_q + 3'd1) == nbytes_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                sdo_oe_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (csb_rise) begin
            state_d     = S_IDLE;
            bitcnt_d    = 3'd0;
            sdo_oe_d    = 1'b0;
            we_d        = 1'b0;
            re_d        = 1'b0;
            inc_pend_d  = 1'b0;
            load_pend_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sdi_sync_q  <= '0;
            state_q     <= S_IDLE;
            mode_q      <= CMD_NOP;
            nbytes_q    <= 3'd0;
            bitcnt_q    <= 3'd0;
            bytecnt_q   <= 3'd0;
            rx_q        <= 8'd0;
            tx_q        <= 8'd0;
            wdata_q     <= 8'd0;
            addr_q      <= '0;
            inc_pend_q  <= 1'b0;
            load_pend_q <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sdi_sync_q  <= sdi_sync_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            nbytes_q    <= nbytes_d;
            bitcnt_q    <= bitcnt_d;
            bytecnt_q   <= bytecnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            inc_pend_q  <= inc_pend_d;
            load_pend_q <= load_pend_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            we_q        <= we_d;
            re_q        <= re_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_sdo    = sdo_q;
    assign spi_sdo_oe = sdo_oe_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_we     = we_q;
    assign reg_re     = re_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_hkspi_responder.sv
// Bench for hkspi_responder: a host drives SPI transactions while a register
// bank answers strobes; expectations come from a transaction-level model.
module tb_hkspi_responder;

    logic       clock = 1'b0;
    logic       reset;
    logic       spi_sck, spi_csb, spi_sdi;
    logic       spi_sdo, spi_sdo_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

    hkspi_responder #(.SYNC_STAGES(2), .ADDR_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .spi_sck    (spi_sck),
        .spi_csb    (spi_csb),
        .spi_sdi    (spi_sdi),
        .spi_sdo    (spi_sdo),
        .spi_sdo_oe (spi_sdo_oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .busy       (busy)
    );

    // Register bank seen by the responder, plus a log of every strobe it issues.
    logic [7:0] init_vals [256];
    logic [7:0] bank      [256];
    logic       load_bank = 1'b0;
    logic [7:0] re_log[$];
    logic [7:0] we_addr_log[$];
    logic [7:0] we_data_log[$];
    int         oe_cycles = 0;

    always @(posedge clock) begin
        if (load_bank) begin
            for (int i = 0; i < 256; i++) bank[i] <= init_vals[i];
        end else if (reg_we) begin
            bank[reg_addr] <= reg_wdata;
        end
        if (reg_re) reg_rdata <= bank[reg_addr];
        if (reg_we) begin
            we_addr_log.push_back(reg_addr);
            we_data_log.push_back(reg_wdata);
        end
        if (reg_re) re_log.push_back(reg_addr);
        if (spi_sdo_oe) oe_cycles <= oe_cycles + 1;
    end

    // Transaction-level expectation state.
    logic [7:0] model    [256];
    logic [7:0] mosi_buf [32];
    logic [7:0] miso_buf [32];
    logic [7:0] oe_buf   [32];
    logic [7:0] exp_rx   [32];
    logic       exp_oe   [32];
    int         exp_re_n, exp_we_n, eff_n;
    logic [7:0] exp_addr_end;
    logic [7:0] last_addr = 8'h00;
    int         re_base, we_base, oe_base;

    task automatic spi_bits(input logic [7:0] mosi, input int nbits,
                            output logic [7:0] miso, output logic [7:0] oe);
        miso = 8'h00;
        oe   = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_sdi = mosi[i];
            #100;
            spi_sck = 1'b1;
            miso[i] = spi_sdo;
            oe[i]   = spi_sdo_oe;
            #100;
            spi_sck = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input int nsent);
        logic [7:0] m, o;
        re_base = re_log.size();
        we_base = we_addr_log.size();
        oe_base = oe_cycles;
        spi_csb = 1'b0;
        #100;
        spi_bits(cmd, 8, m, o);
        spi_bits(addr, 8, m, o);
        for (int k = 0; k < nsent; k++) begin
            spi_bits(mosi_buf[k], 8, m, o);
            miso_buf[k] = m;
            oe_buf[k]   = o;
        end
        #100;
        spi_csb = 1'b1;
        #200;
    endtask

    // Expected behaviour from the command semantics: which bytes are transferred,
    // what each read returns (pre-write contents) and where the address ends up.
    function automatic void predict(input logic [7:0] cmd, input logic [7:0] addr, input int nsent);
        logic [1:0] mode;
        int         n;
        logic       rd, wr;
        logic [7:0] a;
        mode = cmd[7:6];
        n    = int'(cmd[5:3]);
        rd   = mode[0];
        wr   = mode[1];
        if (mode == 2'b00)             eff_n = 0;
        else if (n == 0 || n > nsent)  eff_n = nsent;
        else                           eff_n = n;
        exp_re_n = !rd ? 0 : ((n == 0) ? eff_n + 1 : eff_n);
        exp_we_n = wr ? eff_n : 0;
        for (int k = 0; k < nsent; k++) begin
            a         = addr + 8'(k);
            exp_rx[k] = model[a];
            exp_oe[k] = rd && (k < eff_n);
            if (wr && k < eff_n) model[a] = mosi_buf[k];
        end
        exp_addr_end = (mode == 2'b00) ? last_addr : addr + 8'(eff_n);
        last_addr    = exp_addr_end;
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        load_bank = 1'b1;
        #60;
        checks++;
        if ({spi_sdo, spi_sdo_oe, reg_we, reg_re, busy} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b expected 00000", {spi_sdo, spi_sdo_oe, reg_we, reg_re, busy});
        end
        load_bank = 1'b0;
        reset     = 1'b0;
        #40;
        checks++;
        if (reg_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_addr got %h expected 00", reg_addr);
        end
        checks++;
        if (reg_wdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_wdata got %h expected 00", reg_wdata);
        end
        for (int i = 0; i < 256; i++) model[i] = init_vals[i];
        last_addr = 8'h00;
    endtask

    task automatic test_single_read();
        int hits;
        logic [7:0] first;
        mosi_buf[0] = 8'($urandom);
        run_txn(8'h40, 8'h03, 1);
        predict(8'h40, 8'h03, 1);
        checks++;
        if (miso_buf[0] !== exp_rx[0]) begin
            errors++;
            $display("[TB] FAIL read1_data got %h expected %h", miso_buf[0], exp_rx[0]);
        end
        first = (re_log.size() > re_base) ? re_log[re_base] : 8'hxx;
        checks++;
        if (first !== 8'h03) begin
            errors++;
            $display("[TB] FAIL read1_re_addr got %h expected 03", first);
        end
        hits = 0;
        for (int i = re_base; i < re_log.size(); i++) if (re_log[i] == 8'h03) hits++;
        checks++;
        if (hits !== 1) begin
            errors++;
            $display("[TB] FAIL read1_re_at_3 got %0d expected 1", hits);
        end
        checks++;
        if (oe_buf[0] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL read1_oe got %h expected ff", oe_buf[0]);
        end
        checks++;
        if (we_addr_log.size() - we_base !== 0) begin
            errors++;
            $display("[TB] FAIL read1_we_count got %0d expected 0", we_addr_log.size() - we_base);
        end
    endtask

    task automatic test_single_write();
        logic [7:0] wa, wd;
        mosi_buf[0] = 8'h01;
        run_txn(8'h80, 8'h07, 1);
        predict(8'h80, 8'h07, 1);
        checks++;
        if (we_addr_log.size() - we_base !== exp_we_n) begin
            errors++;
            $display("[TB] FAIL write1_we_count got %0d expected %0d", we_addr_log.size() - we_base, exp_we_n);
        end
        wa = (we_addr_log.size() > we_base) ? we_addr_log[we_base] : 8'hxx;
        wd = (we_data_log.size() > we_base) ? we_data_log[we_base] : 8'hxx;
        checks++;
        if ({wa, wd} !== 16'h0701) begin
            errors++;
            $display("[TB] FAIL write1_strobe got addr %h data %h expected addr 07 data 01", wa, wd);
        end
        checks++;
        if (oe_cycles - oe_base !== 0) begin
            errors++;
            $display("[TB] FAIL write1_oe_cycles got %0d expected 0", oe_cycles - oe_base);
        end
        checks++;
        if (reg_addr !== exp_addr_end) begin
            errors++;
            $display("[TB] FAIL write1_addr_end got %h expected %h", reg_addr, exp_addr_end);
        end
    endtask

    task automatic test_stream_read();
        for (int k = 0; k < 19; k++) mosi_buf[k] = 8'($urandom);
        run_txn(8'h40, 8'h00, 19);
        predict(8'h40, 8'h00, 19);
        for (int k = 0; k < 19; k++) begin
            checks++;
            if (miso_buf[k] !== exp_rx[k]) begin
                errors++;
                $display("[TB] FAIL stream_byte%0d got %h expected %h", k, miso_buf[k], exp_rx[k]);
            end
        end
        checks++;
        if (reg_addr !== exp_addr_end) begin
            errors++;
            $display("[TB] FAIL stream_addr_end got %h expected %h", reg_addr, exp_addr_end);
        end
        checks++;
        if (re_log.size() - re_base !== exp_re_n) begin
            errors++;
            $display("[TB] FAIL stream_re_count got %0d expected %0d", re_log.size() - re_base, exp_re_n);
        end
    endtask

    task automatic test_wrap_limited();
        logic [7:0] ra;
        for (int k = 0; k < 4; k++) mosi_buf[k] = 8'($urandom);
        run_txn(8'h50, 8'hFF, 4);
        predict(8'h50, 8'hFF, 4);
        for (int k = 0; k < 4; k++) begin
            if (exp_oe[k]) begin
                checks++;
                if (miso_buf[k] !== exp_rx[k]) begin
                    errors++;
                    $display("[TB] FAIL wrap_byte%0d got %h expected %h", k, miso_buf[k], exp_rx[k]);
                end
            end
            checks++;
            if (oe_buf[k] !== (exp_oe[k] ? 8'hFF : 8'h00)) begin
                errors++;
                $display("[TB] FAIL wrap_oe%0d got %h expected %h", k, oe_buf[k], exp_oe[k] ? 8'hFF : 8'h00);
            end
        end
        checks++;
        if (re_log.size() - re_base !== exp_re_n) begin
            errors++;
            $display("[TB] FAIL wrap_re_count got %0d expected %0d", re_log.size() - re_base, exp_re_n);
        end
        for (int i = 0; i < exp_re_n; i++) begin
            ra = (re_log.size() > re_base + i) ? re_log[re_base + i] : 8'hxx;
            checks++;
            if (ra !== 8'hFF + 8'(i)) begin
                errors++;
                $display("[TB] FAIL wrap_re_addr%0d got %h expected %h", i, ra, 8'hFF + 8'(i));
            end
        end
        checks++;
        if (reg_addr !== exp_addr_end) begin
            errors++;
            $display("[TB] FAIL wrap_addr_end got %h expected %h", reg_addr, exp_addr_end);
        end
    endtask

    task automatic test_read_write();
        logic [7:0] wa, wd;
        mosi_buf[0] = 8'hAA;
        mosi_buf[1] = 8'hBB;
        run_txn(8'hC0, 8'h10, 2);
        predict(8'hC0, 8'h10, 2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (miso_buf[k] !== exp_rx[k]) begin
                errors++;
                $display("[TB] FAIL rw_old%0d got %h expected %h", k, miso_buf[k], exp_rx[k]);
            end
        end
        checks++;
        if (we_addr_log.size() - we_base !== exp_we_n) begin
            errors++;
            $display("[TB] FAIL rw_we_count got %0d expected %0d", we_addr_log.size() - we_base, exp_we_n);
        end
        for (int k = 0; k < exp_we_n; k++) begin
            wa = (we_addr_log.size() > we_base + k) ? we_addr_log[we_base + k] : 8'hxx;
            wd = (we_data_log.size() > we_base + k) ? we_data_log[we_base + k] : 8'hxx;
            checks++;
            if ({wa, wd} !== {8'h10 + 8'(k), mosi_buf[k]}) begin
                errors++;
                $display("[TB] FAIL rw_we%0d got addr %h data %h expected addr %h data %h",
                         k, wa, wd, 8'h10 + 8'(k), mosi_buf[k]);
            end
        end
    endtask

    task automatic test_abort_and_reset();
        logic [7:0] m, o;
        re_base = re_log.size();
        we_base = we_addr_log.size();
        spi_csb = 1'b0;
        #100;
        spi_bits(8'h80, 8, m, o);
        spi_bits(8'h20, 8, m, o);
        spi_bits(8'h5A, 5, m, o);
        #100;
        spi_csb = 1'b1;
        #200;
        last_addr = 8'h20;
        checks++;
        if (we_addr_log.size() - we_base !== 0) begin
            errors++;
            $display("[TB] FAIL abort_we_count got %0d expected 0", we_addr_log.size() - we_base);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_busy got %b expected 0", busy);
        end

        spi_csb = 1'b0;
        #100;
        spi_bits(8'h40, 8, m, o);
        spi_bits(8'h9A, 4, m, o);
        reset = 1'b1;
        #40;
        checks++;
        if ({reg_re, reg_we, busy, spi_sdo_oe} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL midreset_flags got %b expected 0000", {reg_re, reg_we, busy, spi_sdo_oe});
        end
        reset = 1'b0;
        #100;
        checks++;
        if ({busy, reg_addr} !== 9'h000) begin
            errors++;
            $display("[TB] FAIL midreset_idle got busy %b addr %h expected busy 0 addr 00", busy, reg_addr);
        end
        spi_csb = 1'b1;
        #200;
        last_addr = 8'h00;
        checks++;
        if (re_log.size() - re_base !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_re_count got %0d expected 0", re_log.size() - re_base);
        end

        mosi_buf[0] = 8'($urandom);
        mosi_buf[1] = 8'($urandom);
        run_txn(8'h48, 8'h22, 2);
        predict(8'h48, 8'h22, 2);
        checks++;
        if (miso_buf[0] !== exp_rx[0]) begin
            errors++;
            $display("[TB] FAIL recover_data got %h expected %h", miso_buf[0], exp_rx[0]);
        end
        checks++;
        if (oe_buf[1] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL recover_oe_after got %h expected 00", oe_buf[1]);
        end
        checks++;
        if (reg_addr !== exp_addr_end) begin
            errors++;
            $display("[TB] FAIL recover_addr_end got %h expected %h", reg_addr, exp_addr_end);
        end
    endtask

    task automatic test_random();
        logic [7:0] cmd, addr, wa, wd, ra;
        int         n, nsent, bad;
        for (int t = 0; t < 8; t++) begin
            n     = $urandom_range(0, 7);
            cmd   = {2'($urandom_range(0, 3)), 3'(n), 3'($urandom)};
            addr  = 8'($urandom);
            nsent = (n == 0) ? $urandom_range(1, 5) : n + $urandom_range(0, 2);
            for (int k = 0; k < nsent; k++) mosi_buf[k] = 8'($urandom);
            run_txn(cmd, addr, nsent);
            predict(cmd, addr, nsent);
            for (int k = 0; k < nsent; k++) begin
                if (exp_oe[k]) begin
                    checks++;
                    if (miso_buf[k] !== exp_rx[k]) begin
                        errors++;
                        $display("[TB] FAIL rand%0d_byte%0d cmd %h got %h expected %h", t, k, cmd, miso_buf[k], exp_rx[k]);
                    end
                end
                checks++;
                if (oe_buf[k] !== (exp_oe[k] ? 8'hFF : 8'h00)) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_oe%0d cmd %h got %h expected %h", t, k, cmd, oe_buf[k], exp_oe[k] ? 8'hFF : 8'h00);
                end
            end
            checks++;
            if (we_addr_log.size() - we_base !== exp_we_n) begin
                errors++;
                $display("[TB] FAIL rand%0d_we_count cmd %h got %0d expected %0d", t, cmd, we_addr_log.size() - we_base, exp_we_n);
            end
            for (int k = 0; k < exp_we_n; k++) begin
                wa = (we_addr_log.size() > we_base + k) ? we_addr_log[we_base + k] : 8'hxx;
                wd = (we_data_log.size() > we_base + k) ? we_data_log[we_base + k] : 8'hxx;
                checks++;
                if ({wa, wd} !== {addr + 8'(k), mosi_buf[k]}) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_we%0d got addr %h data %h expected addr %h data %h",
                             t, k, wa, wd, addr + 8'(k), mosi_buf[k]);
                end
            end
            checks++;
            if (re_log.size() - re_base !== exp_re_n) begin
                errors++;
                $display("[TB] FAIL rand%0d_re_count cmd %h got %0d expected %0d", t, cmd, re_log.size() - re_base, exp_re_n);
            end
            for (int i = 0; i < exp_re_n; i++) begin
                ra = (re_log.size() > re_base + i) ? re_log[re_base + i] : 8'hxx;
                checks++;
                if (ra !== addr + 8'(i)) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_re_addr%0d got %h expected %h", t, i, ra, addr + 8'(i));
                end
            end
            checks++;
            if (reg_addr !== exp_addr_end) begin
                errors++;
                $display("[TB] FAIL rand%0d_addr_end cmd %h got %h expected %h", t, cmd, reg_addr, exp_addr_end);
            end
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (bank[i] !== model[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL bank_contents got %0d differing registers expected 0", bad);
        end
    endtask

    initial begin
        reset   = 1'b1;
        spi_sck = 1'b0;
        spi_csb = 1'b1;
        spi_sdi = 1'b0;
        for (int i = 0; i < 256; i++) init_vals[i] = 8'($urandom);
        init_vals[0] = 8'h00;
        init_vals[1] = 8'h04;
        init_vals[2] = 8'h56;
        init_vals[3] = 8'h10;
        #20;
        test_reset();
        test_single_read();
        test_single_write();
        test_stream_read();
        test_wrap_limited();
        test_read_write();
        test_abort_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
